mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL provide these ports: clk  in  1  single system clock, rising edge.
REQ-002 The block SHALL provide these ports: Reset  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL provide these ports: req_valid  in  1, req_ready  out  1  pipeline request handshake.
REQ-004 The block SHALL provide these ports: req_write  in  1 (0 load, 1 store), req_addr  in  32, req_wdata  in  32, req_size  in  2 (00 byte, 01 half, 10 word, 11 illegal), req_signed  in  1 (sign-extend loads).
REQ-005 The block SHALL provide these ports: resp_valid  out  1, resp_ready  in  1, resp_rdata  out  32, resp_err  out  1.
REQ-006 The block SHALL provide these ports to the data RAM: ram_rw  out  1 (1 write), ram_addr  out  32, ram_din  out  32, ram_size  out  2, ram_dout  in  32 (combinational read data; byte in [7:0], half in [15:0]).

Function
REQ-007 The block SHALL implement FSM states IDLE, ACCESS, SPLIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 In IDLE, a cycle with req_valid=1 SHALL capture all req_* fields and classify the request as illegal, aligned or misaligned.
REQ-009 The block SHALL treat a request as illegal when req_size=11 or req_addr+nbytes-1 > 255 (nbytes = 1/2/4); the next state SHALL then be RESP with resp_err=1 and no RAM write.
REQ-010 The block SHALL treat a request as aligned when the size is byte, the size is half with addr[0]=0, or the size is word with addr[1:0]=00; IDLE SHALL then go to ACCESS.
REQ-011 In ACCESS (exactly one cycle) the block SHALL drive ram_addr/ram_size/ram_din from the captured request, assert ram_rw=req_write, latch ram_dout on loads, and go to RESP.
REQ-012 The block SHALL drive ram_rw=1 only in ACCESS/SPLIT cycles of stores; in all other states ram_rw SHALL be 0, ram_addr 0, ram_size 10, ram_din 0.
REQ-013 On stores, ram_din SHALL carry the operand right-justified: byte=wdata[7:0], half=wdata[15:0], word=wdata.
REQ-014 On loads, resp_rdata SHALL be zero-extended, or sign-extended from bit 7/15 when req_signed=1; word loads SHALL ignore req_signed.
REQ-015 In RESP the block SHALL hold resp_valid=1 with stable resp_rdata/resp_err until resp_ready=1, then return to IDLE; a new request SHALL not be accepted in that same cycle.
REQ-016 Latency for an aligned access with resp_ready held at 1 SHALL be: accept at cycle N, RAM access at N+1, resp_valid at N+2.
REQ-017 Store responses SHALL return resp_rdata=0 and resp_err=0.

Reset
REQ-018 On Reset=1, asynchronously, the FSM SHALL go to IDLE, req_ready SHALL be 1, resp_valid/resp_err/resp_rdata/ram_rw/ram_addr/ram_din SHALL be 0, ram_size SHALL be 10, and the byte counter SHALL be 0.
REQ-019 Reset asserted mid-SPLIT SHALL abort the access immediately; bytes already written SHALL remain in RAM and no response SHALL be issued.

Configuration
REQ-020 With MAU_SPLIT_UNALIGNED_EN defined, a misaligned half or word SHALL go to SPLIT: nbytes one-byte accesses at addr+k, k=0..nbytes-1, one per cycle, with a 2-bit counter.
REQ-021 In SPLIT the transfer SHALL be big-endian: store byte k = operand byte (nbytes-1-k) counting from the LSB; load byte k SHALL fill result byte (nbytes-1-k); extension per REQ-014 SHALL be applied after the last byte; then the next state SHALL be RESP.
REQ-022 Without MAU_SPLIT_UNALIGNED_EN, a misaligned half or word SHALL be illegal (RESP with resp_err=1, no RAM write), and the SPLIT state and counter SHALL be absent.

Verification
REQ-023 The bench SHALL cover: store word 0xDEADBEEF at 0x10, then load word 0x10 -> ram_rw high one cycle only; load returns 0xDEADBEEF at N+2, resp_err=0.
REQ-024 The bench SHALL cover: store byte 0x80 at 0x21; load byte 0x21 with signed=1 -> 0xFFFFFF80; with signed=0 -> 0x00000080.
REQ-025 The bench SHALL cover: load word at 0xFE -> resp_err=1, no ram_rw pulse; load with size=11 -> resp_err=1.
REQ-026 The bench SHALL cover: with MAU_SPLIT_UNALIGNED_EN, store word 0x11223344 at 0x41 -> four byte writes 0x11,0x22,0x33,0x44 at 0x41..0x44; load word 0x41 -> 0x11223344, resp_valid at N+5. Without the macro -> resp_err=1 and memory unchanged.
REQ-027 The bench SHALL cover: hold resp_ready=0 for 3 cycles -> resp_valid and data stable, req_ready=0; Reset pulsed after the 2nd split byte -> outputs zero at once, only 0x41..0x42 written.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a request/response pipeline port and a 256-byte data RAM.
// Define MAU_SPLIT_UNALIGNED_EN to break misaligned half/word accesses into big-endian byte accesses.
module mem_access_unit (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic [1:0]  ram_size,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
`ifdef MAU_SPLIT_UNALIGNED_EN
        SPLIT  = 2'd3,
`endif
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                           input logic sgn);
        case (size)
            SZ_BYTE: extend = {{24{sgn & d[7]}}, d[7:0]};
            SZ_HALF: extend = {{16{sgn & d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    function automatic logic [31:0] justify(input logic [31:0] d, input logic [1:0] size);
        case (size)
            SZ_BYTE: justify = {24'b0, d[7:0]};
            SZ_HALF: justify = {16'b0, d[15:0]};
            default: justify = d;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        ram_rw_q, ram_rw_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_din_q, ram_din_d;
    logic [1:0]  ram_size_q, ram_size_d;

    logic [1:0]  req_last;
    logic [32:0] req_end;
    logic        misaligned;
    logic        illegal;

`ifdef MAU_SPLIT_UNALIGNED_EN
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  split_last;
    logic [1:0]  idx;
    logic [1:0]  cnt_next;
    logic [31:0] merged;
    logic [31:0] req_operand;
`endif

    // Index of the last byte of the access: 0 for byte, 1 for half, 3 for word.
    assign req_last   = (req_size == SZ_HALF) ? 2'd1 :
                        (req_size == SZ_WORD) ? 2'd3 : 2'd0;
    assign req_end    = {1'b0, req_addr} + {31'b0, req_last};
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`ifdef MAU_SPLIT_UNALIGNED_EN
    assign illegal    = (req_size == 2'b11) || (req_end > 33'd255);
    assign split_last = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
`else
    assign illegal    = (req_size == 2'b11) || (req_end > 33'd255) || misaligned;
`endif

    always_comb begin
        // NOTE: every signal written below gets a default first so no path can infer a latch.
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        req_ready_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        ram_rw_d     = 1'b0;
        ram_addr_d   = 32'b0;
        ram_din_d    = 32'b0;
        ram_size_d   = SZ_WORD;
`ifdef MAU_SPLIT_UNALIGNED_EN
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        idx          = split_last - cnt_q;
        cnt_next     = cnt_q + 2'd1;
        merged       = acc_q | ({24'b0, ram_dout[7:0]} << {idx, 3'b000});
        req_operand  = justify(req_wdata, req_size);
`endif
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    write_d     = req_write;
                    size_d      = req_size;
                    signed_d    = req_signed;
                    if (illegal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'b0;
                    end else if (!misaligned) begin
                        state_d    = ACCESS;
                        ram_rw_d   = req_write;
                        ram_addr_d = req_addr;
                        ram_size_d = req_size;
                        ram_din_d  = justify(req_wdata, req_size);
                    end
`ifdef MAU_SPLIT_UNALIGNED_EN
                    else begin
                        // Big-endian split: the first byte on the bus is the operand's top byte.
                        state_d    = SPLIT;
                        cnt_d      = 2'd0;
                        addr_d     = req_addr;
                        wdata_d    = req_operand;
                        acc_d      = 32'b0;
                        ram_rw_d   = req_write;
                        ram_addr_d = req_addr;
                        ram_size_d = SZ_BYTE;
                        ram_din_d  = {24'b0, 8'(req_operand >> {req_last, 3'b000})};
                    end
`endif
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = write_q ? 32'b0 : extend(ram_dout, size_q, signed_q);
            end
`ifdef MAU_SPLIT_UNALIGNED_EN
            SPLIT: begin
                acc_d = merged;
                if (cnt_q == split_last) begin
                    state_d      = RESP;
                    cnt_d        = 2'd0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = write_q ? 32'b0 : extend(merged, size_q, signed_q);
                end else begin
                    cnt_d      = cnt_next;
                    ram_rw_d   = write_q;
                    ram_addr_d = addr_q + {30'b0, cnt_next};
                    ram_size_d = SZ_BYTE;
                    ram_din_d  = {24'b0, 8'(wdata_q >> {idx - 2'd1, 3'b000})};
                end
            end
`endif
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= SZ_WORD;
            signed_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= 32'b0;
            ram_din_q    <= 32'b0;
            ram_size_q   <= SZ_WORD;
`ifdef MAU_SPLIT_UNALIGNED_EN
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            acc_q        <= 32'b0;
            cnt_q        <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_size_q   <= ram_size_d;
`ifdef MAU_SPLIT_UNALIGNED_EN
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign ram_rw     = ram_rw_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_size   = ram_size_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a little-endian 256-byte RAM model and write log.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req_valid, req_write, req_signed, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, resp_valid, resp_err, ram_rw;
    logic [31:0] resp_rdata, ram_addr, ram_din, ram_dout;
    logic [1:0]  ram_size;

    logic [7:0]  mem [0:255];
    int          wr_count = 0;
    logic [15:0] wr_log [$];
    int          n_total = 0;
    int          n_bad = 0;

    logic [31:0] rd;
    logic        er;
    int          lat, nwr;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din), .ram_size(ram_size),
        .ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (ram_rw) begin
            wr_count <= wr_count + 1;
            case (ram_size)
                2'b00: begin
                    mem[ram_addr[7:0]] <= ram_din[7:0];
                    wr_log.push_back({ram_addr[7:0], ram_din[7:0]});
                end
                2'b01: begin
                    mem[ram_addr[7:0]]         <= ram_din[7:0];
                    mem[8'(ram_addr[7:0] + 1)] <= ram_din[15:8];
                end
                default: begin
                    mem[ram_addr[7:0]]         <= ram_din[7:0];
                    mem[8'(ram_addr[7:0] + 1)] <= ram_din[15:8];
                    mem[8'(ram_addr[7:0] + 2)] <= ram_din[23:16];
                    mem[8'(ram_addr[7:0] + 3)] <= ram_din[31:24];
                end
            endcase
        end
    end

    always_comb begin
        ram_dout = 32'b0;
        case (ram_size)
            2'b00:   ram_dout = {24'b0, mem[ram_addr[7:0]]};
            2'b01:   ram_dout = {16'b0, mem[8'(ram_addr[7:0] + 1)], mem[ram_addr[7:0]]};
            default: ram_dout = {mem[8'(ram_addr[7:0] + 3)], mem[8'(ram_addr[7:0] + 2)],
                                 mem[8'(ram_addr[7:0] + 1)], mem[ram_addr[7:0]]};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request; lat counts cycles from the accept edge to the first cycle with resp_valid.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic sg, input int hold,
                          output logic [31:0] rdo, output logic ero, output int lato,
                          output int nwro);
        int base;
        base = wr_count;
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = wd;
        req_size   = sz;
        req_signed = sg;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lato = 0;
        while (lato < 20) begin
            @(negedge clk);
            lato++;
            if (resp_valid) break;
        end
        check("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
        check("no_accept_in_resp", {31'b0, req_ready}, 32'd0);
        rdo = resp_rdata;
        ero = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, resp_valid}, 32'd1);
            check("stall_rdata", resp_rdata, rdo);
            check("stall_err", {31'b0, resp_err}, {31'b0, ero});
            check("stall_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resp_dropped", {31'b0, resp_valid}, 32'd0);
        nwro = wr_count - base;
    endtask

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        Reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0; resp_ready = 1'b1;
        req_addr = 32'b0; req_wdata = 32'b0; req_size = 2'b10;
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_ram_rw", {31'b0, ram_rw}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_din", ram_din, 32'd0);
        check("rst_ram_size", {30'b0, ram_size}, 32'd2);
        @(negedge clk);
        Reset = 1'b0;

        // Aligned word store then load back.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, rd, er, lat, nwr);
        check("sw_lat", lat, 32'd2);
        check("sw_err", {31'b0, er}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("sw_writes", nwr, 32'd1);
        check("sw_mem", mem_word(8'h10), 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b1, 0, rd, er, lat, nwr);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_lat", lat, 32'd2);
        check("lw_err", {31'b0, er}, 32'd0);
        check("lw_writes", nwr, 32'd0);

        // Byte store takes only the low operand byte; loads sign/zero extend.
        do_req(1'b1, 32'h21, 32'h12345680, 2'b00, 1'b0, 0, rd, er, lat, nwr);
        check("sb_writes", nwr, 32'd1);
        check("sb_mem", {24'b0, mem[8'h21]}, 32'h80);
        check("sb_mem_next", {24'b0, mem[8'h22]}, 32'h00);
        do_req(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 0, rd, er, lat, nwr);
        check("lb_signed", rd, 32'hFFFFFF80);
        do_req(1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 0, rd, er, lat, nwr);
        check("lb_unsigned", rd, 32'h00000080);

        do_req(1'b1, 32'h30, 32'hABCD8001, 2'b01, 1'b0, 0, rd, er, lat, nwr);
        check("sh_mem", {16'b0, mem[8'h31], mem[8'h30]}, 32'h8001);
        check("sh_mem_next", {24'b0, mem[8'h32]}, 32'h00);
        do_req(1'b0, 32'h30, 32'h0, 2'b01, 1'b1, 0, rd, er, lat, nwr);
        check("lh_signed", rd, 32'hFFFF8001);
        do_req(1'b0, 32'h30, 32'h0, 2'b01, 1'b0, 0, rd, er, lat, nwr);
        check("lh_unsigned", rd, 32'h00008001);

        // Range and size errors; the last bytes of the space stay legal.
        do_req(1'b0, 32'hFE, 32'h0, 2'b10, 1'b0, 0, rd, er, lat, nwr);
        check("lw_fe_err", {31'b0, er}, 32'd1);
        check("lw_fe_writes", nwr, 32'd0);
        check("lw_fe_rdata", rd, 32'd0);
        do_req(1'b0, 32'h00, 32'h0, 2'b11, 1'b0, 0, rd, er, lat, nwr);
        check("size11_err", {31'b0, er}, 32'd1);
        do_req(1'b1, 32'hFC, 32'h01020304, 2'b10, 1'b0, 0, rd, er, lat, nwr);
        check("sw_fc_err", {31'b0, er}, 32'd0);
        check("sw_fc_mem", mem_word(8'hFC), 32'h01020304);
        do_req(1'b1, 32'hFF, 32'h0000BEEF, 2'b01, 1'b0, 0, rd, er, lat, nwr);
        check("sh_ff_err", {31'b0, er}, 32'd1);
        check("sh_ff_writes", nwr, 32'd0);
        check("sh_ff_mem", {24'b0, mem[8'hFF]}, 32'h01);
        do_req(1'b1, 32'hFF, 32'h0000005A, 2'b00, 1'b0, 0, rd, er, lat, nwr);
        check("sb_ff_err", {31'b0, er}, 32'd0);
        check("sb_ff_mem", {24'b0, mem[8'hFF]}, 32'h5A);

        // Back-pressure on the response port.
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 3, rd, er, lat, nwr);
        check("stall_lw_rdata", rd, 32'hDEADBEEF);

`ifdef MAU_SPLIT_UNALIGNED_EN
        wr_log.delete();
        do_req(1'b1, 32'h41, 32'h11223344, 2'b10, 1'b0, 0, rd, er, lat, nwr);
        check("split_sw_err", {31'b0, er}, 32'd0);
        check("split_sw_writes", nwr, 32'd4);
        check("split_sw_lat", lat, 32'd5);
        check("split_log_len", wr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_log.size())
                check("split_log_entry", {16'b0, wr_log[i]},
                      {16'b0, 8'(8'h41 + i), 8'(8'h11 * (i + 1))});
        end
        do_req(1'b0, 32'h41, 32'h0, 2'b10, 1'b1, 0, rd, er, lat, nwr);
        check("split_lw_rdata", rd, 32'h11223344);
        check("split_lw_lat", lat, 32'd5);
        check("split_lw_writes", nwr, 32'd0);
        do_req(1'b1, 32'h51, 32'h00009988, 2'b01, 1'b0, 0, rd, er, lat, nwr);
        check("split_sh_mem", {16'b0, mem[8'h51], mem[8'h52]}, 32'h9988);
        do_req(1'b0, 32'h51, 32'h0, 2'b01, 1'b1, 0, rd, er, lat, nwr);
        check("split_lh_signed", rd, 32'hFFFF9988);
        check("split_lh_lat", lat, 32'd3);

        // Reset after the second byte of a split store aborts it silently.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h41;
        req_wdata = 32'hAABBCCDD; req_size = 2'b10; req_signed = 1'b0; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 Reset = 1'b1;
        #1;
        check("abort_ram_rw", {31'b0, ram_rw}, 32'd0);
        check("abort_ram_addr", ram_addr, 32'd0);
        check("abort_ram_size", {30'b0, ram_size}, 32'd2);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        check("abort_mem", mem_word(8'h41), 32'h4433BBAA);
`else
        do_req(1'b1, 32'h41, 32'h11223344, 2'b10, 1'b0, 0, rd, er, lat, nwr);
        check("mis_sw_err", {31'b0, er}, 32'd1);
        check("mis_sw_writes", nwr, 32'd0);
        check("mis_sw_mem", mem_word(8'h41), 32'h00000000);
        do_req(1'b0, 32'h31, 32'h0, 2'b01, 1'b0, 0, rd, er, lat, nwr);
        check("mis_lh_err", {31'b0, er}, 32'd1);
        check("mis_lh_rdata", rd, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
